// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Frame results carry a kind plus the key code, which is zero unless the kind is RES_SINGLE.
package key_scan_pkg;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } frame_res_t;

    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned NUM_ROWS  = 4;
    localparam logic [3:0]  COL_RESET = 4'b1110;

    localparam frame_res_t RES_CLEAR = '{kind: RES_NONE, code: 4'h0};

    // Number of rows pulled low in one column sample.
    function automatic logic [2:0] count_low(input logic [3:0] rows_n);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            n = n + {2'b00, ~rows_n[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Enable generator: one-cycle tick every SIZE clocks, first tick SIZE clocks after reset.
module key_scan_tick #(
    parameter int unsigned SIZE = 60000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned W = (SIZE > 1) ? $clog2(SIZE) : 1;

    if (SIZE < 2) begin : g_bad_size
        $error("key_scan_tick: SIZE must be at least 2");
    end

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 hex keypad scanner: column drive, row synchronisation, frame accumulation,
// frame-level debounce and a press/release FSM producing a registered key code and strobe.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 60000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("key_scan: DEBOUNCE_FRAMES must be in 2..15");
    end

    logic [3:0] row_meta;
    logic [3:0] row_sync;
    logic       tick;
    logic [1:0] col_idx;
    frame_res_t acc;
    frame_res_t acc_next;
    frame_res_t cand;
    logic [3:0] stable_cnt;
    logic [3:0] stable_next;
    logic [1:0] row_sel;
    logic [2:0] n_low;
    logic       frame_end;
    logic       same;
    logic       accept;
    state_e     state;

    key_scan_tick #(
        .SIZE(SCAN_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_comb begin
        n_low   = count_low(row_sync);
        row_sel = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync[r]) begin
                row_sel = 2'(r);
            end
        end

        // Any second intersection in the frame, in this column or an earlier one, makes it MULTI.
        acc_next = acc;
        if (n_low > 3'd1 || (n_low == 3'd1 && acc.kind != RES_NONE)) begin
            acc_next = '{kind: RES_MULTI, code: 4'h0};
        end else if (n_low == 3'd1) begin
            acc_next = '{kind: RES_SINGLE, code: {row_sel, col_idx}};
        end

        frame_end = tick && (col_idx == 2'(NUM_COLS - 1));
        same      = (acc_next == cand);

        if (!same) begin
            stable_next = 4'd1;
        end else if (stable_cnt == 4'(DEBOUNCE_FRAMES)) begin
            stable_next = stable_cnt;
        end else begin
            stable_next = stable_cnt + 4'd1;
        end

        // Counter only climbs to the limit from limit-1 with a matching result.
        accept = frame_end && same && (stable_cnt == 4'(DEBOUNCE_FRAMES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_n      <= COL_RESET;
            col_idx    <= '0;
            acc        <= RES_CLEAR;
            cand       <= RES_CLEAR;
            stable_cnt <= '0;
        end else if (tick) begin
            col_n   <= {col_n[2:0], col_n[3]};
            col_idx <= col_idx + 2'd1;
            if (frame_end) begin
                acc        <= RES_CLEAR;
                cand       <= acc_next;
                stable_cnt <= stable_next;
            end else begin
                acc <= acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        if (acc_next.kind == RES_SINGLE) begin
                            state     <= ST_PRESSED;
                            key_code  <= acc_next.code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        // Other keys or chords are ignored until a stable release.
                        if (acc_next.kind == RES_NONE) begin
                            state    <= ST_IDLE;
                            key_held <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model drives rows from the held key set, and a frame-level
// reference model (window debounce over a result history) predicts every output cycle by cycle.
module tb_key_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    int pulses = 0;

    logic [15:0] mask_ring [FRAME];
    int          res_q [$];
    logic        m_pressed = 1'b0;
    logic [3:0]  m_code    = 4'h0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_col   = 4'b1110;

    key_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r * 4 + c] && col_n[c] === 1'b0) row_n[r] = 1'b0;
            end
        end
    end

    // -1 = no key, -2 = several keys, otherwise the single key's code.
    function automatic int frame_result(input logic [15:0] seen);
        int n;
        int code;
        n = 0;
        code = 0;
        for (int k = 0; k < 16; k++) begin
            if (seen[k]) begin
                n++;
                code = k;
            end
        end
        if (n == 0) return -1;
        if (n > 1) return -2;
        return code;
    endfunction

    // Accepted when the last DEB results agree and the run is exactly DEB long.
    function automatic bit just_accepted();
        int n;
        int last;
        n = res_q.size();
        if (n < DEB) return 1'b0;
        last = res_q[n - 1];
        for (int i = 1; i < DEB; i++) begin
            if (res_q[n - 1 - i] != last) return 1'b0;
        end
        if (n == DEB) return 1'b1;
        return res_q[n - 1 - DEB] != last;
    endfunction

    // Advance one clock with the given key set and update the reference model.
    task automatic step(input logic [15:0] mask);
        logic [15:0] seen;
        logic [15:0] m;
        int r;
        keys = mask;
        @(posedge clk);
        ecnt++;
        mask_ring[ecnt % FRAME] = mask;
        exp_valid = 1'b0;
        if (ecnt % FRAME == 0) begin
            seen = '0;
            for (int c = 0; c < 4; c++) begin
                // Column c is read two clocks (synchroniser) before its sampling tick.
                m = mask_ring[(ecnt - FRAME + SCAN_DIV * (c + 1) - 2) % FRAME];
                for (int k = c; k < 16; k += 4) begin
                    if (m[k]) seen[k] = 1'b1;
                end
            end
            r = frame_result(seen);
            res_q.push_back(r);
            if (just_accepted()) begin
                if (!m_pressed && r >= 0) begin
                    m_pressed = 1'b1;
                    m_code    = r[3:0];
                    exp_valid = 1'b1;
                end else if (m_pressed && r == -1) begin
                    m_pressed = 1'b0;
                end
            end
        end
        exp_col = 4'hF;
        exp_col[(ecnt / SCAN_DIV) % 4] = 1'b0;
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
        res_q.delete();
        m_pressed = 1'b0;
        m_code    = 4'h0;
        total++;
        if ({col_n, key_valid, key_held, key_code} !== {4'b1110, 1'b0, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL reset_values: col/valid/held/code got %b/%b/%b/%h want 1110/0/0/0",
                     col_n, key_valid, key_held, key_code);
        end
    endtask

    task automatic test_reset();
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            step(16'h0000);
            total++;
            if ({col_n, key_valid, key_held, key_code} !==
                {exp_col, exp_valid, m_pressed, m_code}) begin
                bad++;
                $display("FAIL idle_scan @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                         ecnt, col_n, key_valid, key_held, key_code,
                         exp_col, exp_valid, m_pressed, m_code);
            end
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL idle_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_single_press();
        logic [15:0] mk [2];
        int fr [2];
        mk = '{16'h0200, 16'h0000};
        fr = '{5 + int'($urandom_range(0, 3)), 5};
        pulses = 0;
        foreach (mk[s]) begin
            for (int i = 0; i < fr[s] * FRAME; i++) begin
                step(mk[s]);
                total++;
                if ({col_n, key_valid, key_held, key_code} !==
                    {exp_col, exp_valid, m_pressed, m_code}) begin
                    bad++;
                    $display("FAIL single_press @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                             ecnt, col_n, key_valid, key_held, key_code,
                             exp_col, exp_valid, m_pressed, m_code);
                end
            end
        end
        total++;
        if (pulses !== 1 || key_code !== 4'h9 || key_held !== 1'b0) begin
            bad++;
            $display("FAIL single_summary: pulses/code/held got %0d/%h/%b want 1/9/0",
                     pulses, key_code, key_held);
        end
    endtask

    task automatic test_bounce();
        int phase;
        logic [15:0] m;
        phase = int'($urandom_range(0, 11));
        pulses = 0;
        for (int i = 0; i < 8 * FRAME + 5 * FRAME; i++) begin
            if (i >= 8 * FRAME) m = 16'h0020;
            else m = (((i + phase) / 12) % 2 == 0) ? 16'h0020 : 16'h0000;
            step(m);
            total++;
            if ({col_n, key_valid, key_held, key_code} !==
                {exp_col, exp_valid, m_pressed, m_code}) begin
                bad++;
                $display("FAIL bounce @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                         ecnt, col_n, key_valid, key_held, key_code,
                         exp_col, exp_valid, m_pressed, m_code);
            end
            if (i == 8 * FRAME - 1) begin
                total++;
                if (pulses !== 0) begin
                    bad++;
                    $display("FAIL bounce_quiet: pulses got %0d want 0", pulses);
                end
            end
        end
        total++;
        if (pulses !== 1 || key_code !== 4'h5) begin
            bad++;
            $display("FAIL bounce_hold: pulses/code got %0d/%h want 1/5", pulses, key_code);
        end
        for (int i = 0; i < 5 * FRAME; i++) step(16'h0000);
    endtask

    task automatic test_multi();
        logic [15:0] mk [5];
        int fr [5];
        mk = '{16'h1008, 16'h0008, 16'h0000, 16'h0008, 16'h0000};
        fr = '{5, 2, 4, 5, 5};
        pulses = 0;
        foreach (mk[s]) begin
            for (int i = 0; i < fr[s] * FRAME; i++) begin
                step(mk[s]);
                total++;
                if ({col_n, key_valid, key_held, key_code} !==
                    {exp_col, exp_valid, m_pressed, m_code}) begin
                    bad++;
                    $display("FAIL multi @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                             ecnt, col_n, key_valid, key_held, key_code,
                             exp_col, exp_valid, m_pressed, m_code);
                end
            end
            if (s == 2) begin
                total++;
                if (pulses !== 0) begin
                    bad++;
                    $display("FAIL multi_no_pulse: pulses got %0d want 0", pulses);
                end
            end
        end
        total++;
        if (pulses !== 1 || key_code !== 4'h3) begin
            bad++;
            $display("FAIL multi_repress: pulses/code got %0d/%h want 1/3", pulses, key_code);
        end
    endtask

    task automatic test_no_rollover();
        logic [15:0] mk [3];
        int fr [3];
        mk = '{16'h0400, 16'h0800, 16'h0000};
        fr = '{4, 5, 5};
        pulses = 0;
        foreach (mk[s]) begin
            for (int i = 0; i < fr[s] * FRAME; i++) begin
                step(mk[s]);
                total++;
                if ({col_n, key_valid, key_held, key_code} !==
                    {exp_col, exp_valid, m_pressed, m_code}) begin
                    bad++;
                    $display("FAIL rollover @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                             ecnt, col_n, key_valid, key_held, key_code,
                             exp_col, exp_valid, m_pressed, m_code);
                end
            end
        end
        total++;
        if (pulses !== 1 || key_code !== 4'hA) begin
            bad++;
            $display("FAIL rollover_summary: pulses/code got %0d/%h want 1/a", pulses, key_code);
        end
    endtask

    task automatic test_reset_mid();
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) step(16'h0080);
        do_reset();
        for (int i = 0; i < 8 * FRAME; i++) begin
            step(i < 3 * FRAME ? 16'h0080 : 16'h0000);
            total++;
            if ({col_n, key_valid, key_held, key_code} !==
                {exp_col, exp_valid, m_pressed, m_code}) begin
                bad++;
                $display("FAIL reset_mid @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                         ecnt, col_n, key_valid, key_held, key_code,
                         exp_col, exp_valid, m_pressed, m_code);
            end
            if (i == 2 * FRAME - 1) begin
                total++;
                if (pulses !== 0) begin
                    bad++;
                    $display("FAIL reset_mid_early: pulses got %0d want 0", pulses);
                end
            end
        end
        total++;
        if (pulses !== 1 || key_code !== 4'h7) begin
            bad++;
            $display("FAIL reset_mid_summary: pulses/code got %0d/%h want 1/7", pulses, key_code);
        end
    endtask

    task automatic test_random();
        int kind;
        int a;
        int b;
        int nf;
        logic [15:0] m;
        for (int s = 0; s < 26; s++) begin
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = (a + int'($urandom_range(1, 15))) % 16;
            m    = '0;
            if (kind != 0) m[a] = 1'b1;
            if (kind == 3) m[b] = 1'b1;
            nf = (s == 25) ? 5 : int'($urandom_range(1, 5));
            if (s == 25) m = '0;
            for (int i = 0; i < nf * FRAME; i++) begin
                step(m);
                total++;
                if ({col_n, key_valid, key_held, key_code} !==
                    {exp_col, exp_valid, m_pressed, m_code}) begin
                    bad++;
                    $display("FAIL random @%0d: col/valid/held/code got %b/%b/%b/%h want %b/%b/%b/%h",
                             ecnt, col_n, key_valid, key_held, key_code,
                             exp_col, exp_valid, m_pressed, m_code);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_no_rollover();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
